// File: rtl/rstsrcctrl.sv
// rtl/rstsrcctrl.sv - reset sequencer merging POR, filtered pin and software/watchdog causes into resetff
// Watchdog cause and WDTRF flag exist only when RSTCTRL_WDT_EN is defined.
module rstsrcctrl #(
  parameter int         RST_FILT    = 4,
  parameter int         RST_STRETCH = 16,
  parameter logic [6:0] RSTSRC_ID   = 7'h4F
) (
  input  logic       clkcpu,
  input  logic       reset,
  input  logic       rstn_pin,
  input  logic       srstreq,
  input  logic       wdtreq,
  input  logic [6:0] sfraddr,
  input  logic [7:0] sfrdatai,
  input  logic       sfrwe,
  output logic       resetff,
  output logic [7:0] sfrdatao
);

  typedef enum logic {ST_RUN = 1'b0, ST_HOLD = 1'b1} state_t;

  localparam logic [3:0] LP_FILT   = 4'(RST_FILT);
  localparam logic [7:0] LP_RELOAD = 8'(RST_STRETCH - 1);

  logic [1:0] r_sync;
  logic [3:0] r_filt;
  logic       w_ext_act;
  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       r_resetff;
  logic [2:0] r_flags;        // {SWRF, EXTRF, PORF}
  logic [2:0] w_flags_nxt;
  logic       w_wdt;
  logic       w_any_cause;
  logic       w_sfr_hit;
  logic       w_w1c;
  logic [3:0] w_rstsrc;

  // Pin assertion must persist RST_FILT synchronized samples; release is immediate.
  always_ff @(posedge clkcpu) begin
    if (reset) begin
      r_sync <= 2'b00;
      r_filt <= 4'd0;
    end else begin
      r_sync <= {r_sync[0], ~rstn_pin};
      if (!r_sync[1]) begin
        r_filt <= 4'd0;
      end else if (r_filt != LP_FILT) begin
        r_filt <= r_filt + 4'd1;
      end
    end
  end

  assign w_ext_act   = (r_filt == LP_FILT);
  assign w_sfr_hit   = (sfraddr == RSTSRC_ID);
  assign w_w1c       = sfrwe && w_sfr_hit && (r_state == ST_RUN);
  assign w_any_cause = w_wdt | srstreq | w_ext_act;

`ifdef RSTCTRL_WDT_EN
  logic       r_wdtrf;
  logic [3:0] w_unused;

  assign w_wdt    = wdtreq;
  assign w_unused = sfrdatai[7:4];
  assign w_rstsrc = {r_wdtrf, r_flags};

  always_ff @(posedge clkcpu) begin
    if (reset) begin
      r_wdtrf <= 1'b0;
    end else if (w_wdt) begin
      r_wdtrf <= 1'b1;
    end else if ((r_state == ST_RUN) && w_any_cause) begin
      r_wdtrf <= 1'b0;
    end else if (w_w1c && sfrdatai[3]) begin
      r_wdtrf <= 1'b0;
    end
  end
`else
  logic [5:0] w_unused;

  assign w_wdt    = 1'b0;
  assign w_unused = {wdtreq, sfrdatai[7:3]};
  assign w_rstsrc = {1'b0, r_flags};
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_flags_nxt = r_flags;
    case (r_state)
      ST_RUN: begin
        if (w_any_cause) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = LP_RELOAD;
          w_flags_nxt = {srstreq, w_ext_act, 1'b0};
        end else if (w_w1c) begin
          w_flags_nxt = r_flags & ~sfrdatai[2:0];
        end
      end
      ST_HOLD: begin
        w_flags_nxt = r_flags | {srstreq, w_ext_act, 1'b0};
        if (w_any_cause) begin
          w_cnt_nxt = LP_RELOAD;
        end else if (r_cnt == 8'd0) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_HOLD;
        w_cnt_nxt   = LP_RELOAD;
      end
    endcase
  end

  always_ff @(posedge clkcpu) begin
    if (reset) begin
      r_state   <= ST_HOLD;
      r_cnt     <= LP_RELOAD;
      r_flags   <= 3'b001;
      r_resetff <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_flags   <= w_flags_nxt;
      r_resetff <= (w_state_nxt == ST_HOLD);
    end
  end

  assign resetff  = r_resetff;
  assign sfrdatao = w_sfr_hit ? {4'h0, w_rstsrc} : 8'h00;

endmodule

// File: tb/tb_rstsrcctrl.sv
// tb/tb_rstsrcctrl.sv - directed and randomized bench for rstsrcctrl against a cycle-history reference model
module tb_rstsrcctrl;

  localparam int         FILT    = 4;
  localparam int         STRETCH = 16;
  localparam logic [6:0] ID      = 7'h4F;
`ifdef RSTCTRL_WDT_EN
  localparam bit WDT = 1'b1;
`else
  localparam bit WDT = 1'b0;
`endif

  logic       clkcpu = 1'b0;
  logic       reset, rstn_pin, srstreq, wdtreq, sfrwe;
  logic [6:0] sfraddr;
  logic [7:0] sfrdatai;
  logic       resetff;
  logic [7:0] sfrdatao;

  int checks = 0;
  int errors = 0;

  // Model: low-pin run lengths ending at the last three edges, edges since last cause, flags.
  int         r1 = 0, r2 = 0, r3 = 0;
  int         since = 0;
  logic       m_rff = 1'b1;
  logic [3:0] m_flags = 4'h1;

  rstsrcctrl dut (
    .clkcpu   (clkcpu),
    .reset    (reset),
    .rstn_pin (rstn_pin),
    .srstreq  (srstreq),
    .wdtreq   (wdtreq),
    .sfraddr  (sfraddr),
    .sfrdatai (sfrdatai),
    .sfrwe    (sfrwe),
    .resetff  (resetff),
    .sfrdatao (sfrdatao)
  );

  always #5 clkcpu = ~clkcpu;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model_step();
    logic       hold_prev;
    logic       c_ext;
    logic [3:0] cb;
    int         newrun;
    hold_prev = m_rff;
    c_ext     = (r3 >= FILT);
    cb        = {(WDT ? wdtreq : 1'b0), srstreq, c_ext, 1'b0};
    if (reset) begin
      m_flags = 4'h1;
      since   = 0;
      r1 = 0; r2 = 0; r3 = 0;
    end else begin
      if (cb != 4'h0) begin
        since   = 0;
        m_flags = hold_prev ? (m_flags | cb) : cb;
      end else begin
        if (since < 1000) since++;
        if (!hold_prev && sfrwe && sfraddr == ID) m_flags = m_flags & ~sfrdatai[3:0];
      end
      newrun = !rstn_pin ? r1 + 1 : 0;
      r3 = r2; r2 = r1; r1 = newrun;
    end
    m_rff = (since < STRETCH);
  endfunction

  task automatic tick();
    @(posedge clkcpu);
    model_step();
    #1;
    chk("resetff", {7'h0, resetff}, {7'h0, m_rff});
    chk("sfrdatao", sfrdatao, (sfraddr == ID) ? {4'h0, m_flags} : 8'h00);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_idle();
    reset = 1'b0; rstn_pin = 1'b1; srstreq = 1'b0; wdtreq = 1'b0;
    sfrwe = 1'b0; sfraddr = ID; sfrdatai = 8'h00;
  endtask

  initial begin
    int pin_left;
    set_idle();
    reset = 1'b1;
    ticks(3);
    reset = 1'b0;
    ticks(15);
    chk("por_still_high", {7'h0, resetff}, 8'h01);
    tick();
    chk("por_released", {7'h0, resetff}, 8'h00);
    chk("por_rstsrc", sfrdatao, 8'h01);
    sfrwe = 1'b1; sfrdatai = 8'h01;
    tick();
    sfrwe = 1'b0;
    chk("por_w1c", sfrdatao, 8'h00);

    srstreq = 1'b1;
    tick();
    srstreq = 1'b0;
    ticks(15);
    chk("sw_high", {7'h0, resetff}, 8'h01);
    tick();
    chk("sw_low", {7'h0, resetff}, 8'h00);
    chk("sw_rstsrc", sfrdatao, 8'h04);
    ticks(4);

    rstn_pin = 1'b0;
    ticks(3);
    rstn_pin = 1'b1;
    ticks(10);
    chk("glitch_noreset", {7'h0, resetff}, 8'h00);
    chk("glitch_rstsrc", sfrdatao, 8'h04);

    rstn_pin = 1'b0;
    ticks(6);
    chk("pin_not_yet", {7'h0, resetff}, 8'h00);
    tick();
    chk("pin_rise", {7'h0, resetff}, 8'h01);
    ticks(13);
    rstn_pin = 1'b1;
    ticks(40);
    chk("pin_rstsrc", sfrdatao, 8'h02);

    srstreq = 1'b1;
    tick();
    srstreq = 1'b0;
    ticks(3);
    rstn_pin = 1'b0;
    ticks(10);
    rstn_pin = 1'b1;
    ticks(6);
    chk("overlap_stretch", {7'h0, resetff}, 8'h01);
    ticks(40);
    chk("overlap_rstsrc", sfrdatao, 8'h06);

    wdtreq = 1'b1; sfrwe = 1'b1; sfrdatai = 8'hFF;
    tick();
    wdtreq = 1'b0; sfrwe = 1'b0;
    if (WDT) begin
      chk("wdt_resetff", {7'h0, resetff}, 8'h01);
      chk("wdt_rstsrc", sfrdatao, 8'h08);
    end else begin
      chk("nowdt_resetff", {7'h0, resetff}, 8'h00);
      chk("nowdt_bit3", {7'h0, sfrdatao[3]}, 8'h00);
    end
    ticks(20);

    pin_left = 0;
    for (int c = 0; c < 3000; c++) begin
      reset   = ($urandom_range(0, 199) == 0);
      srstreq = ($urandom_range(0, 59) == 0);
      wdtreq  = ($urandom_range(0, 79) == 0);
      if (pin_left == 0) begin
        if ($urandom_range(0, 2) == 0) begin
          rstn_pin = 1'b0;
          pin_left = $urandom_range(1, 12);
        end else begin
          rstn_pin = 1'b1;
          pin_left = $urandom_range(5, 60);
        end
      end
      pin_left--;
      sfrwe    = ($urandom_range(0, 3) == 0);
      sfraddr  = ($urandom_range(0, 1) == 0) ? ID : 7'($urandom);
      sfrdatai = 8'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rstsrcctrl.md
# rstsrcctrl

- Central reset sequencer for the 8051 core.
- Merges three reset sources into the single stretched, registered core reset `resetff`:
  - power-on `reset`;
  - filtered external reset pin;
  - `srstreq` from the software-reset controller, plus optional watchdog.
- Records the cause in a read-only-by-CPU, write-1-to-clear SFR (RSTSRC).
- Sits directly downstream of the software-reset controller. Its `resetff` output feeds every CPU-domain block, including that controller.

## Interface
- `RST_FILT`, 4 — consecutive synchronized samples of pin assertion required before an external reset is accepted; range 1..15.
- `RST_STRETCH`, 16 — cycles `resetff` stays high after the last active cause; range 1..255.
- `RSTSRC_ID`, 7'h4F — SFR address of RSTSRC.
- `clkcpu`  in  1  single clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high power-on reset.
- `rstn_pin`  in  1  external reset pin, active-low, asynchronous to `clkcpu`.
- `srstreq`  in  1  software reset request, level; drops once `resetff` asserts.
- `wdtreq`  in  1  watchdog reset request, level (used only with `RSTCTRL_WDT_EN`).
- `sfraddr`  in  7  SFR address.
- `sfrdatai`  in  8  SFR write data.
- `sfrwe`  in  1  SFR write strobe.
- `resetff`  out  1  registered core reset, active-high.
- `sfrdatao`  out  8  RSTSRC contents when `sfraddr==RSTSRC_ID`, else 8'h00; combinational.

## Operation
- Pin path:
  - two-flop synchronizer on `~rstn_pin` produces `ext_s`;
  - 4-bit filter counter increments while `ext_s`=1 and saturates at `RST_FILT`; clears to 0 when `ext_s`=0.
  - `ext_act` = (filter count == `RST_FILT`). Deassertion is not filtered.
- Cause vector: `cause` = {`wdtreq` (gated by config), `srstreq`, `ext_act`}.
- FSM, two states:
  - RUN: `resetff`=0. Any `cause` bit set → HOLD, stretch counter loaded with `RST_STRETCH`-1.
  - HOLD: `resetff`=1.
    - While any `cause` is active, the counter reloads to `RST_STRETCH`-1.
    - Otherwise it decrements; at 0 with no active cause → RUN.
- RSTSRC flag register, reset value 8'h01:
  - bit0 PORF, bit1 EXTRF, bit2 SWRF, bit3 WDTRF; bits 7:4 read 0.
  - Entering HOLD: the register loads exactly the active cause bits and clears all others, so the latest reset overwrites history.
  - In HOLD: newly active causes OR in.
  - SFR write to `RSTSRC_ID` in RUN clears each bit written 1 (W1C). Writes in HOLD are ignored.
  - If a set and a W1C hit the same cycle, the set wins.
  - Flags are unaffected by `resetff`; only `reset` and the rules above change them.
- `reset` forces:
  - `resetff`=1, FSM=HOLD, counter=`RST_STRETCH`-1;
  - synchronizer and filter=0;
  - RSTSRC=8'h01.
- `reset` mid-HOLD restarts the stretch from full length and overwrites the flags to 8'h01.

## Timing
- `resetff` during `reset`=1 is 1, and stays 1 for `RST_STRETCH` cycles after `reset` drops.
- Software/watchdog cause sampled high at edge N → `resetff`=1 after edge N+1... precisely, `resetff` registered high from edge N.
- `resetff` falls `RST_STRETCH` edges after the last edge at which any cause was sampled high.
- Pin path: pin low held steadily → `ext_act` asserts after 2 (synchronizer) + `RST_FILT` edges; `resetff` rises on the following edge.
- Pin glitch shorter than `RST_FILT` synchronized cycles → no reset, no flag.
- `sfrdatao` has zero latency. W1C takes effect on the edge with `sfrwe`=1.

## Configuration
- `RSTCTRL_WDT_EN` defined:
  - `wdtreq` is a reset cause;
  - WDTRF (bit3) is implemented.
- `RSTCTRL_WDT_EN` undefined:
  - `wdtreq` is ignored and no logic is generated for it;
  - bit3 reads constant 0 and W1C to it has no effect.

## Test plan
- Power-on: `reset`=1 for 3 cycles → `resetff`=1 throughout and for exactly 16 cycles after release; RSTSRC reads 8'h01; write 8'h01 → reads 8'h00.
- Software reset: `srstreq`=1 for 1 cycle in RUN → `resetff` high 16 cycles; RSTSRC=8'h04; PORF cleared.
- Pin reset:
  - `rstn_pin` low 3 cycles → no reset;
  - low 20 cycles → `resetff` rises 7 edges after the pin falls and falls 16 cycles after `ext_act` drops;
  - RSTSRC=8'h02.
- Overlap: `srstreq` then pin assert during HOLD → stretch restarts; RSTSRC=8'h06.
- Set vs clear: W1C 8'hFF on the same cycle that `wdtreq` rises (WDT_EN) → bit3 set; `resetff` asserts.
- WDT off: build without `RSTCTRL_WDT_EN`, pulse `wdtreq` → no reset; RSTSRC bit3=0.
